// File: rtl/xnor_stream_checker_pkg.sv
// Shared types and constants for the XNOR stream checker.
package xnor_chk_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    REPORT = 2'd2
  } state_e;

  localparam int CNT_W_DEF = 16;
  localparam logic [CNT_W_DEF-1:0] NO_ERR = '1;

endpackage

// File: rtl/xnor_stream_checker_if.sv
// Sample-stream and report-handshake bundle between the stimulus/collector side and the checker.
interface xnor_stream_checker_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic             sample_valid;
  logic             ref_bit;
  logic             dut_bit;
  logic             stop;
  logic             report_ready;
  logic             busy;
  logic             report_valid;
  logic             pass;
  logic [CNT_W-1:0] samples;
  logic [CNT_W-1:0] errors;
  logic [CNT_W-1:0] first_err;

  modport master (
    output start, sample_valid, ref_bit, dut_bit, stop, report_ready,
    input  busy, report_valid, pass, samples, errors, first_err
  );

  modport slave (
    input  start, sample_valid, ref_bit, dut_bit, stop, report_ready,
    output busy, report_valid, pass, samples, errors, first_err
  );
endinterface

// File: rtl/xnor_stream_checker_sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module xnor_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/xnor_stream_checker.sv
// Lockstep reference/DUT bit-stream comparator with a one-shot valid/ready report.
// Optional early stop at ERR_LIMIT mismatches when STREAM_CHK_LIMIT_EN is defined.
module xnor_stream_checker
  import xnor_chk_pkg::*;
#(
  parameter int CNT_W     = CNT_W_DEF,
  parameter int ERR_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  xnor_stream_checker_if.slave  bus
);

`ifdef STREAM_CHK_LIMIT_EN
  localparam bit LIMIT_EN = 1'b1;
`else
  localparam bit LIMIT_EN = 1'b0;
`endif

  state_e           state_q, state_d;
  logic             busy_q, busy_d;
  logic             rv_q, rv_d;
  logic             pass_q, pass_d;
  logic [CNT_W-1:0] first_err_q, first_err_d;
  logic [CNT_W-1:0] samples_cnt, errors_cnt;
  logic             run_start, smp_inc, err_inc, cnt_clr, limit_hit, handshake;

  assign run_start = (state_q == IDLE) && bus.start;
  assign smp_inc   = (state_q == RUN) && bus.sample_valid;
  assign err_inc   = smp_inc && (~(bus.ref_bit ^ bus.dut_bit) == 1'b0);
  assign cnt_clr   = reset || run_start;
  assign handshake = rv_q && bus.report_ready;
  // Early stop fires on the edge where this mismatch brings errors up to the limit.
  assign limit_hit = LIMIT_EN && err_inc && ((int'(errors_cnt) + 1) == ERR_LIMIT);

  xnor_sat_counter #(.WIDTH(CNT_W)) u_samples (
    .clk (clk),
    .clr (cnt_clr),
    .inc (smp_inc),
    .cnt (samples_cnt)
  );

  xnor_sat_counter #(.WIDTH(CNT_W)) u_errors (
    .clk (clk),
    .clr (cnt_clr),
    .inc (err_inc),
    .cnt (errors_cnt)
  );

  always_comb begin
    state_d     = state_q;
    first_err_d = first_err_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d     = RUN;
          first_err_d = '1;
        end
      end
      RUN: begin
        if (err_inc && (errors_cnt == '0)) first_err_d = samples_cnt;
        if (bus.stop || limit_hit) state_d = REPORT;
      end
      REPORT: begin
        if (handshake) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (reset) begin
      state_d     = IDLE;
      first_err_d = '1;
    end
  end

  // Outputs are registered from the next state so they line up with the state register.
  assign busy_d = (state_d == RUN);
  assign rv_d   = (state_d == REPORT);
  assign pass_d = rv_d && (errors_cnt == '0) && !err_inc;

  always_ff @(posedge clk) begin
    state_q     <= state_d;
    busy_q      <= busy_d;
    rv_q        <= rv_d;
    pass_q      <= pass_d;
    first_err_q <= first_err_d;
  end

  assign bus.busy         = busy_q;
  assign bus.report_valid = rv_q;
  assign bus.pass         = pass_q;
  assign bus.samples      = samples_cnt;
  assign bus.errors       = errors_cnt;
  assign bus.first_err    = first_err_q;

endmodule

// File: tb/tb_xnor_stream_checker.sv
// Directed bench for xnor_stream_checker: a 16-bit instance plus a 4-bit instance for saturation.
module tb_xnor_stream_checker;
  import xnor_chk_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  xnor_stream_checker_if #(.CNT_W(16)) b16 ();
  xnor_stream_checker_if #(.CNT_W(4))  b4 ();

  xnor_stream_checker #(.CNT_W(16), .ERR_LIMIT(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (b16.slave)
  );

  xnor_stream_checker #(.CNT_W(4), .ERR_LIMIT(8)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (b4.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle16();
    b16.start = 0; b16.sample_valid = 0; b16.ref_bit = 0; b16.dut_bit = 0;
    b16.stop = 0; b16.report_ready = 0;
  endtask

  task automatic sample16(input logic r, input logic d);
    b16.sample_valid = 1; b16.ref_bit = r; b16.dut_bit = d;
    tick();
    b16.sample_valid = 0;
  endtask

  task automatic chk_reset16(input string tag);
    chk({tag, ".busy"},      32'(b16.busy), 32'd0);
    chk({tag, ".rv"},        32'(b16.report_valid), 32'd0);
    chk({tag, ".pass"},      32'(b16.pass), 32'd0);
    chk({tag, ".samples"},   32'(b16.samples), 32'd0);
    chk({tag, ".errors"},    32'(b16.errors), 32'd0);
    chk({tag, ".first_err"}, 32'(b16.first_err), 32'(NO_ERR));
  endtask

  initial begin
    reset = 1;
    idle16();
    b4.start = 0; b4.sample_valid = 0; b4.ref_bit = 0; b4.dut_bit = 0;
    b4.stop = 0; b4.report_ready = 0;
    tick(); tick();
    reset = 0;
    repeat (5) tick();
    chk_reset16("rst");
    chk("rst4.first_err", 32'(b4.first_err), 32'hF);

    // Clean run of 10 matching samples, ready already high at report.
    b16.start = 1; tick(); b16.start = 0;
    chk("r1.busy", 32'(b16.busy), 32'd1);
    for (int i = 0; i < 10; i++) sample16(1'(i), 1'(i));
    b16.stop = 1; b16.report_ready = 1; tick(); b16.stop = 0;
    chk("r1.rv", 32'(b16.report_valid), 32'd1);
    chk("r1.samples", 32'(b16.samples), 32'd10);
    chk("r1.errors", 32'(b16.errors), 32'd0);
    chk("r1.first_err", 32'(b16.first_err), 32'hFFFF);
    chk("r1.pass", 32'(b16.pass), 32'd1);
    tick();
    chk("r1.rv_drop", 32'(b16.report_valid), 32'd0);
    chk("r1.busy_idle", 32'(b16.busy), 32'd0);
    b16.report_ready = 0;

    // Mismatches at 3 and 6, ninth matching sample alongside stop.
    b16.start = 1; tick(); b16.start = 0;
    for (int i = 0; i < 8; i++) sample16(1'b1, (i == 3 || i == 6) ? 1'b0 : 1'b1);
    b16.sample_valid = 1; b16.ref_bit = 0; b16.dut_bit = 0; b16.stop = 1;
    tick();
    idle16();
    chk("r2.rv", 32'(b16.report_valid), 32'd1);
    chk("r2.samples", 32'(b16.samples), 32'd9);
    chk("r2.errors", 32'(b16.errors), 32'd2);
    chk("r2.first_err", 32'(b16.first_err), 32'd3);
    chk("r2.pass", 32'(b16.pass), 32'd0);

    // Hold off ready while poking every other input; report must stay frozen.
    for (int i = 0; i < 4; i++) begin
      b16.sample_valid = ~1'(i); b16.stop = 1'(i); b16.start = ~1'(i);
      b16.ref_bit = 1; b16.dut_bit = 0;
      tick();
      chk("r3.rv_hold", 32'(b16.report_valid), 32'd1);
      chk("r3.samples", 32'(b16.samples), 32'd9);
      chk("r3.errors", 32'(b16.errors), 32'd2);
    end
    idle16();
    chk("r3.first_err", 32'(b16.first_err), 32'd3);
    b16.report_ready = 1; tick(); b16.report_ready = 0;
    chk("r3.rv_drop", 32'(b16.report_valid), 32'd0);
    chk("r3.samples_kept", 32'(b16.samples), 32'd9);

    // Back-to-back start, then reset in the middle of the run.
    b16.start = 1; tick(); b16.start = 0;
    chk("r4.busy", 32'(b16.busy), 32'd1);
    chk("r4.samples_clr", 32'(b16.samples), 32'd0);
    sample16(1'b1, 1'b0);
    sample16(1'b0, 1'b1);
    chk("r4.errors", 32'(b16.errors), 32'd2);
    reset = 1; tick(); reset = 0;
    chk_reset16("r4rst");
    tick();
    chk("r4.rv_none", 32'(b16.report_valid), 32'd0);

    // Fresh run after reset: mismatch at index 1 only.
    b16.start = 1; tick(); b16.start = 0;
    sample16(1'b0, 1'b0);
    sample16(1'b1, 1'b0);
    sample16(1'b1, 1'b1);
    b16.stop = 1; b16.report_ready = 1; tick(); b16.stop = 0;
    chk("r5.rv", 32'(b16.report_valid), 32'd1);
    chk("r5.samples", 32'(b16.samples), 32'd3);
    chk("r5.errors", 32'(b16.errors), 32'd1);
    chk("r5.first_err", 32'(b16.first_err), 32'd1);
    chk("r5.pass", 32'(b16.pass), 32'd0);
    tick(); b16.report_ready = 0;

    // Minimum run: start then stop on the next cycle.
    b16.start = 1; tick(); b16.start = 0;
    b16.stop = 1; tick(); b16.stop = 0;
    chk("r6.rv", 32'(b16.report_valid), 32'd1);
    chk("r6.samples", 32'(b16.samples), 32'd0);
    chk("r6.pass", 32'(b16.pass), 32'd1);
    chk("r6.first_err", 32'(b16.first_err), 32'hFFFF);
    b16.report_ready = 1; tick(); b16.report_ready = 0;

    // 4-bit instance: 20 mismatching samples.
    b4.start = 1; tick(); b4.start = 0;
    for (int i = 0; i < 20; i++) begin
      b4.sample_valid = 1; b4.ref_bit = 1'(i); b4.dut_bit = ~1'(i);
      tick();
    end
    b4.sample_valid = 0; b4.stop = 1; tick(); b4.stop = 0;
    chk("sat.rv", 32'(b4.report_valid), 32'd1);
`ifdef STREAM_CHK_LIMIT_EN
    chk("sat.samples", 32'(b4.samples), 32'd8);
    chk("sat.errors", 32'(b4.errors), 32'd8);
`else
    chk("sat.samples", 32'(b4.samples), 32'd15);
    chk("sat.errors", 32'(b4.errors), 32'd15);
`endif
    chk("sat.first_err", 32'(b4.first_err), 32'd0);
    chk("sat.pass", 32'(b4.pass), 32'd0);
    b4.report_ready = 1; tick(); b4.report_ready = 0;
    chk("sat.rv_drop", 32'(b4.report_valid), 32'd0);

    // 12 mismatching samples against the error limit of 8.
    b16.start = 1; tick(); b16.start = 0;
    for (int i = 0; i < 8; i++) sample16(1'b0, 1'b1);
`ifdef STREAM_CHK_LIMIT_EN
    chk("lim.rv_early", 32'(b16.report_valid), 32'd1);
`else
    chk("lim.rv_early", 32'(b16.report_valid), 32'd0);
`endif
    for (int i = 0; i < 4; i++) sample16(1'b0, 1'b1);
    b16.stop = 1; tick(); b16.stop = 0;
    chk("lim.rv", 32'(b16.report_valid), 32'd1);
`ifdef STREAM_CHK_LIMIT_EN
    chk("lim.samples", 32'(b16.samples), 32'd8);
    chk("lim.errors", 32'(b16.errors), 32'd8);
`else
    chk("lim.samples", 32'(b16.samples), 32'd12);
    chk("lim.errors", 32'(b16.errors), 32'd12);
`endif
    chk("lim.first_err", 32'(b16.first_err), 32'd0);
    b16.report_ready = 1; tick(); b16.report_ready = 0;
    chk("lim.rv_drop", 32'(b16.report_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
